// File: rtl/m_timer_pkg.sv
// rtl/m_timer_pkg.sv - shared types, defaults and BCD helper for time-field counters
package m_timer_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_REPEAT = 2'd2,
    RPT_LOCK   = 2'd3
  } rpt_state_t;

  localparam int DEF_HOLD_CYC   = 50;
  localparam int DEF_REPEAT_CYC = 10;

  // Packs {tens, units} for values 0..99.
  function automatic logic [7:0] bcd_split(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/m_key_repeat.sv
// rtl/m_key_repeat.sv - press-and-hold auto-repeat step generator for two buttons
module m_key_repeat
  import m_timer_pkg::*;
#(
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int REPEAT_CYC = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic btn_up,
  input  logic btn_down,
  output logic step_up,
  output logic step_dn,
  output logic adj_active
);

  localparam int TMR_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_END = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] RPT_END  = TMR_W'(REPEAT_CYC - 1);

  rpt_state_t       state;
  logic [TMR_W-1:0] timer;
  logic             dir_up;
  logic             one_btn;
  logic             held;
  logic             other;
  logic             fire;

  assign one_btn = btn_up ^ btn_down;
  assign held    = dir_up ? btn_up : btn_down;
  assign other   = dir_up ? btn_down : btn_up;

  // Steps are decoded from the current state so the counter moves on the sampling edge.
  always_comb begin
    fire = 1'b0;
    if (en) begin
      case (state)
        RPT_IDLE:   fire = one_btn;
        RPT_HOLD:   fire = held && !other && (timer == HOLD_END);
        RPT_REPEAT: fire = held && !other && (timer == RPT_END);
        default:    fire = 1'b0;
      endcase
    end
  end

  assign step_up = fire && ((state == RPT_IDLE) ? btn_up : dir_up);
  assign step_dn = fire && !((state == RPT_IDLE) ? btn_up : dir_up);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RPT_IDLE;
      timer      <= '0;
      dir_up     <= 1'b0;
      adj_active <= 1'b0;
    end else if (!en) begin
      state      <= RPT_IDLE;
      timer      <= '0;
      adj_active <= 1'b0;
    end else begin
      case (state)
        RPT_IDLE: begin
          if (btn_up && btn_down) begin
            state <= RPT_LOCK;
          end else if (one_btn) begin
            state      <= RPT_HOLD;
            dir_up     <= btn_up;
            timer      <= '0;
            adj_active <= 1'b1;
          end
        end
        RPT_HOLD, RPT_REPEAT: begin
          if (!held) begin
            state      <= RPT_IDLE;
            timer      <= '0;
            adj_active <= 1'b0;
          end else if (other) begin
            state      <= RPT_LOCK;
            timer      <= '0;
            adj_active <= 1'b0;
          end else if (fire) begin
            state <= RPT_REPEAT;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          if (!btn_up && !btn_down) state <= RPT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/m_mod_counter_adj.sv
// rtl/m_mod_counter_adj.sv - modulo-N time-field counter with BCD outputs, carry and hold-to-repeat adjust
module m_mod_counter_adj
  import m_timer_pkg::*;
#(
  parameter int  MOD        = 60,
  parameter int  HOLD_CYC   = DEF_HOLD_CYC,
  parameter int  REPEAT_CYC = DEF_REPEAT_CYC,
  localparam int CNT_W      = $clog2(MOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             stop,
  input  logic             sel,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] q_bin,
  output logic [3:0]       q_tens,
  output logic [3:0]       q_units,
  output logic             carry_out,
  output logic             adj_active
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOD - 1);
  localparam logic [CNT_W:0]   MOD_EXT = (CNT_W + 1)'(MOD);

  logic             step_up;
  logic             step_dn;
  logic [CNT_W-1:0] cnt_nxt;
  logic             carry_nxt;

  m_key_repeat #(
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC)
  ) u_key_repeat (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (stop & sel),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .adj_active(adj_active)
  );

  // Manual steps wrap silently so adjusting one field never ripples into the next.
  always_comb begin
    cnt_nxt   = q_bin;
    carry_nxt = 1'b0;
    if (load) begin
      cnt_nxt = ({1'b0, load_val} >= MOD_EXT) ? CNT_MAX : load_val;
    end else if (step_up) begin
      cnt_nxt = (q_bin == CNT_MAX) ? '0 : q_bin + CNT_W'(1);
    end else if (step_dn) begin
      cnt_nxt = (q_bin == '0) ? CNT_MAX : q_bin - CNT_W'(1);
    end else if (tick && !stop) begin
      if (q_bin == CNT_MAX) begin
        cnt_nxt   = '0;
        carry_nxt = 1'b1;
      end else begin
        cnt_nxt = q_bin + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_bin     <= '0;
      q_tens    <= '0;
      q_units   <= '0;
      carry_out <= 1'b0;
    end else begin
      q_bin               <= cnt_nxt;
      {q_tens, q_units}   <= bcd_split(7'(cnt_nxt));
      carry_out           <= carry_nxt;
    end
  end

endmodule

// File: tb/tb_m_mod_counter_adj.sv
// tb/tb_m_mod_counter_adj.sv - scoreboard bench for m_mod_counter_adj
module tb_m_mod_counter_adj;

  localparam int MOD  = 60;
  localparam int HOLD = 4;
  localparam int RPT  = 2;
  localparam int CW   = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          tick = 1'b0;
  logic          stop = 1'b0;
  logic          sel = 1'b0;
  logic          btn_up = 1'b0;
  logic          btn_down = 1'b0;
  logic          load = 1'b0;
  logic [CW-1:0] load_val = '0;
  logic [CW-1:0] q_bin;
  logic [3:0]    q_tens;
  logic [3:0]    q_units;
  logic          carry_out;
  logic          adj_active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int q;
    int carry;
    int adj;
  } exp_t;

  exp_t sb[$];

  int m_cnt  = 0;
  int m_mode = 0;
  int m_n    = 0;
  bit m_dir  = 1'b0;

  m_mod_counter_adj #(
    .MOD       (MOD),
    .HOLD_CYC  (HOLD),
    .REPEAT_CYC(RPT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .stop      (stop),
    .sel       (sel),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .load      (load),
    .load_val  (load_val),
    .q_bin     (q_bin),
    .q_tens    (q_tens),
    .q_units   (q_units),
    .carry_out (carry_out),
    .adj_active(adj_active)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: counts consecutive held cycles instead of tracking a timer.
  task automatic model_push();
    bit en, su, sd, held, other;
    int carry;
    exp_t e;
    en = stop && sel;
    su = 1'b0;
    sd = 1'b0;
    carry = 0;
    if (!en) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (btn_up && btn_down) m_mode = 2;
      else if (btn_up != btn_down) begin
        m_dir = btn_up; m_n = 0; m_mode = 1; su = btn_up; sd = btn_down;
      end
    end else if (m_mode == 1) begin
      held  = m_dir ? btn_up : btn_down;
      other = m_dir ? btn_down : btn_up;
      if (!held) m_mode = 0;
      else if (other) m_mode = 2;
      else begin
        m_n++;
        if (m_n == HOLD || (m_n > HOLD && (m_n - HOLD) % RPT == 0)) begin
          su = m_dir; sd = !m_dir;
        end
      end
    end else if (!btn_up && !btn_down) begin
      m_mode = 0;
    end
    if (load) m_cnt = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
    else if (su) m_cnt = (m_cnt + 1) % MOD;
    else if (sd) m_cnt = (m_cnt + MOD - 1) % MOD;
    else if (tick && !stop) begin
      if (m_cnt == MOD - 1) carry = 1;
      m_cnt = (m_cnt + 1) % MOD;
    end
    e.q = m_cnt;
    e.carry = carry;
    e.adj = (m_mode == 1) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic cycle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      model_push();
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_val("q_bin", 32'(q_bin), e.q);
      check_val("q_tens", 32'(q_tens), e.q / 10);
      check_val("q_units", 32'(q_units), e.q % 10);
      check_val("carry_out", 32'(carry_out), e.carry);
      check_val("adj_active", 32'(adj_active), e.adj);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_q_bin"}, 32'(q_bin), 0);
    check_val({tag, "_q_tens"}, 32'(q_tens), 0);
    check_val({tag, "_q_units"}, 32'(q_units), 0);
    check_val({tag, "_carry"}, 32'(carry_out), 0);
    check_val({tag, "_adj"}, 32'(adj_active), 0);
  endtask

  task automatic set_in(input bit t, input bit s, input bit sl, input bit u, input bit d);
    tick = t; stop = s; sel = sl; btn_up = u; btn_down = d;
  endtask

  task automatic do_load(input int v, input bit t);
    load = 1'b1; load_val = CW'(v); tick = t;
    cycle(1);
    load = 1'b0; tick = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Auto count through a full wrap.
    set_in(1, 0, 0, 0, 0);
    cycle(62);
    set_in(0, 0, 0, 0, 0);
    cycle(2);

    // Gating: tick ignored while stopped, buttons ignored without sel.
    set_in(1, 1, 0, 0, 0);
    cycle(3);
    set_in(0, 1, 0, 1, 0);
    cycle(5);
    sel = 1'b1;
    cycle(7);
    set_in(0, 1, 1, 0, 0);
    cycle(2);

    // Load beats tick; then hold-repeat across the wrap.
    stop = 1'b0;
    do_load(58, 1);
    set_in(0, 1, 1, 1, 0);
    cycle(10);
    btn_up = 1'b0;
    cycle(2);

    // Down wrap, lock, release, up.
    do_load(0, 0);
    btn_down = 1'b1;
    cycle(1);
    btn_down = 1'b0;
    cycle(1);
    set_in(0, 1, 1, 1, 1);
    cycle(20);
    set_in(0, 1, 1, 0, 0);
    cycle(1);
    btn_up = 1'b1;
    cycle(1);
    btn_up = 1'b0;
    cycle(2);

    // Load saturation and load-vs-tick.
    stop = 1'b0;
    do_load(63, 0);
    do_load(45, 1);
    cycle(1);

    // Random mix.
    for (int i = 0; i < 300; i++) begin
      tick     = ($urandom_range(0, 2) != 0);
      stop     = ($urandom_range(0, 3) != 0);
      sel      = ($urandom_range(0, 5) != 0);
      btn_up   = ($urandom_range(0, 3) == 0) ? ~btn_up : btn_up;
      btn_down = ($urandom_range(0, 7) == 0) ? ~btn_down : btn_down;
      load     = ($urandom_range(0, 30) == 0);
      load_val = CW'($urandom_range(0, 63));
      cycle(1);
    end
    set_in(0, 1, 1, 0, 0);
    load = 1'b0;
    cycle(2);

    // Asynchronous reset in REPEAT, then a held button counts as a fresh press.
    btn_up = 1'b1;
    cycle(8);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    sb.delete();
    m_cnt = 0; m_mode = 0; m_n = 0;
    #2 rst_n = 1'b1;
    cycle(1);
    check_val("post_rst_q", 32'(q_bin), 1);
    cycle(6);
    btn_up = 1'b0;
    cycle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
